// File: rtl/barrel_feeder.sv
// barrel_feeder: FIFO of shift commands feeding a single-entry issue stage
// that drives the barrel shifter and returns its result over valid/ready.
module barrel_feeder #(
   parameter int DEPTH = 4,
   parameter int KW    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [7:0]                 cmd_data,
   input  logic [KW-1:0]              cmd_k,
   input  logic                       cmd_dir,
   output logic [7:0]                 sh_in,
   output logic [KW-1:0]              sh_k,
   output logic                       sh_dir,
   input  logic [7:0]                 sh_out,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [7:0]                 res_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = 9 + KW;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t        state_q, state_d;
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    sh_in_q, sh_in_d;
   logic [KW-1:0] sh_k_q, sh_k_d;
   logic          sh_dir_q, sh_dir_d;
   logic          push, pop;
   assign cmd_ready = count_q != CW'(DEPTH);
   assign res_valid = state_q == BUSY;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (count_q != '0) && (!res_valid || res_ready);
   assign res_data  = sh_out;
   assign count     = count_q;
   assign sh_in     = sh_in_q;
   assign sh_k      = sh_k_q;
   assign sh_dir    = sh_dir_q;
   always_comb begin
      wp_d    = push ? wp_q + 1'b1 : wp_q;
      rp_d    = pop ? rp_q + 1'b1 : rp_q;
      count_d = count_q + CW'(push) - CW'(pop);
      {sh_in_d, sh_k_d, sh_dir_d} = pop ? mem_q[rp_q] : {sh_in_q, sh_k_q, sh_dir_q};
      state_d = pop ? BUSY : (res_valid && res_ready) ? IDLE : state_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         wp_q     <= '0;
         rp_q     <= '0;
         count_q  <= '0;
         sh_in_q  <= '0;
         sh_k_q   <= '0;
         sh_dir_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         count_q  <= count_d;
         sh_in_q  <= sh_in_d;
         sh_k_q   <= sh_k_d;
         sh_dir_q <= sh_dir_d;
      end
   end
   // Storage carries no reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= {cmd_data, cmd_k, cmd_dir};
   end
endmodule

// File: tb/tb_barrel_feeder.sv
// tb_barrel_feeder: scoreboard bench for barrel_feeder with a behavioural
// barrel shifter closing the sh_* -> sh_out loop.
module tb_barrel_feeder;
   logic       clk = 1'b0, rst = 1'b1;
   logic       cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0, sh_dir;
   logic [7:0] cmd_data = '0, sh_in, sh_out, res_data;
   logic [3:0] cmd_k = '0, sh_k;
   logic       res_valid, res_ready = 1'b0;
   logic [2:0] count;
   logic [7:0] q[$];
   logic [7:0] e, prev_sh;
   logic       prev_hold;
   int         n_chk = 0, n_pass = 0, first_v, last_v, n_v;

   always #5 clk = ~clk;

   function automatic logic [7:0] bmodel(input logic [7:0] d, input logic [3:0] k, input logic dir);
      bmodel = dir ? (d << k) : (d >> k);
   endfunction

   assign sh_out = bmodel(sh_in, sh_k, sh_dir);

   barrel_feeder #(.DEPTH(4), .KW(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_data(cmd_data), .cmd_k(cmd_k), .cmd_dir(cmd_dir),
      .sh_in(sh_in), .sh_k(sh_k), .sh_dir(sh_dir), .sh_out(sh_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .count(count)
   );

   task automatic test_reset();
      #1;
      n_chk++; if ({count, res_valid, cmd_ready, sh_in, sh_k, sh_dir} !== {3'd0, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0})
         $display("FAIL por_state got cnt=%0d rv=%b rdy=%b sh=%h/%h/%b", count, res_valid, cmd_ready, sh_in, sh_k, sh_dir); else n_pass++;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); cmd_valid = 1'b1; cmd_data = 8'h30 + 8'(i); cmd_k = 4'(i); cmd_dir = 1'b1;
         if (cmd_valid && cmd_ready) q.push_back(bmodel(cmd_data, cmd_k, cmd_dir));
      end
      @(negedge clk); cmd_valid = 1'b0;
      n_chk++; if (count !== 3'd3 || res_valid !== 1'b1) $display("FAIL pre_rst got cnt=%0d rv=%b want 3/1", count, res_valid); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_chk++; if ({count, res_valid, cmd_ready, sh_in, sh_k, sh_dir} !== {3'd0, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0})
         $display("FAIL async_rst got cnt=%0d rv=%b rdy=%b sh=%h/%h/%b", count, res_valid, cmd_ready, sh_in, sh_k, sh_dir); else n_pass++;
      q.delete();
      @(negedge clk); rst = 1'b0; res_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_chk++; if (res_valid !== 1'b0 || count !== 3'd0) $display("FAIL stale_after_rst got rv=%b cnt=%0d want 0/0", res_valid, count); else n_pass++;
      end
   endtask

   task automatic test_single();
      @(negedge clk); cmd_valid = 1'b1; cmd_data = 8'h55; cmd_k = 4'd1; cmd_dir = 1'b1; res_ready = 1'b1;
      if (cmd_valid && cmd_ready) q.push_back(bmodel(cmd_data, cmd_k, cmd_dir));
      @(negedge clk); cmd_valid = 1'b0;
      n_chk++; if (res_valid !== 1'b0) $display("FAIL single_no_bypass got rv=%b want 0", res_valid); else n_pass++;
      @(negedge clk);
      n_chk++; if ({sh_in, sh_k, sh_dir, res_valid} !== {8'h55, 4'd1, 1'b1, 1'b1})
         $display("FAIL single_issue got sh=%h/%h/%b rv=%b want 55/1/1 rv=1", sh_in, sh_k, sh_dir, res_valid); else n_pass++;
      if (res_valid && res_ready) begin
         n_chk++;
         if (q.size() == 0) $display("FAIL single_res got unexpected %h", res_data);
         else begin e = q.pop_front(); if (res_data !== e) $display("FAIL single_res got %h want %h", res_data, e); else n_pass++; end
      end
      @(negedge clk);
      n_chk++; if (res_valid !== 1'b0) $display("FAIL single_done got rv=%b want 0", res_valid); else n_pass++;
   endtask

   task automatic test_stream();
      n_v = 0; first_v = -1; last_v = -1; res_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         cmd_valid = c < 6;
         cmd_data = 8'h55; cmd_k = 4'(1 << (c / 2)); cmd_dir = ~c[0];
         if (cmd_valid && cmd_ready) q.push_back(bmodel(cmd_data, cmd_k, cmd_dir));
         if (res_valid && res_ready) begin
            n_chk++; n_v++; last_v = c; if (first_v < 0) first_v = c;
            if (q.size() == 0) $display("FAIL stream_res got unexpected %h", res_data);
            else begin e = q.pop_front(); if (res_data !== e) $display("FAIL stream_res got %h want %h", res_data, e); else n_pass++; end
         end
      end
      n_chk++; if (n_v != 6 || last_v - first_v != 5) $display("FAIL stream_contig got %0d results over span %0d want 6/5", n_v, last_v - first_v); else n_pass++;
   endtask

   task automatic test_full();
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); cmd_valid = 1'b1; cmd_data = 8'h10 + 8'(i); cmd_k = 4'(i); cmd_dir = i[0];
         if (cmd_valid && cmd_ready) q.push_back(bmodel(cmd_data, cmd_k, cmd_dir));
      end
      @(negedge clk); cmd_data = 8'hEE; cmd_k = 4'd3; cmd_dir = 1'b1;
      n_chk++; if ({count, cmd_ready, res_valid, sh_in} !== {3'd4, 1'b0, 1'b1, 8'h10})
         $display("FAIL full_state got cnt=%0d rdy=%b rv=%b sh_in=%h want 4/0/1/10", count, cmd_ready, res_valid, sh_in); else n_pass++;
      for (int c = 0; c < 3; c++) begin
         if (cmd_valid && cmd_ready) q.push_back(bmodel(cmd_data, cmd_k, cmd_dir));
         @(negedge clk);
         n_chk++; if ({count, sh_in, sh_k, sh_dir} !== {3'd4, 8'h10, 4'd0, 1'b0})
            $display("FAIL full_hold got cnt=%0d sh=%h/%h/%b want 4/10/0/0", count, sh_in, sh_k, sh_dir); else n_pass++;
      end
      cmd_valid = 1'b0; res_ready = 1'b1;
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
         if (res_valid && res_ready) begin
            n_chk++; e = q.pop_front();
            if (res_data !== e) $display("FAIL full_drain got %h want %h", res_data, e); else n_pass++;
         end
         @(negedge clk);
      end
      n_chk++; if (q.size() != 0 || res_valid !== 1'b0 || count !== 3'd0)
         $display("FAIL full_end got left=%0d rv=%b cnt=%0d want 0/0/0", q.size(), res_valid, count); else n_pass++;
   endtask

   task automatic test_back_to_back();
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); cmd_valid = 1'b1; cmd_data = 8'h20 + 8'(i); cmd_k = 4'(i + 1); cmd_dir = ~i[0];
         if (cmd_valid && cmd_ready) q.push_back(bmodel(cmd_data, cmd_k, cmd_dir));
      end
      @(negedge clk); cmd_data = 8'h23; cmd_k = 4'd5; cmd_dir = 1'b0; res_ready = 1'b1;
      n_chk++; if (count !== 3'd2 || res_valid !== 1'b1) $display("FAIL bb_pre got cnt=%0d rv=%b want 2/1", count, res_valid); else n_pass++;
      if (cmd_valid && cmd_ready) q.push_back(bmodel(cmd_data, cmd_k, cmd_dir));
      if (res_valid && res_ready) begin
         n_chk++; e = q.pop_front();
         if (res_data !== e) $display("FAIL bb_res got %h want %h", res_data, e); else n_pass++;
      end
      @(negedge clk); cmd_valid = 1'b0; res_ready = 1'b0;
      n_chk++; if (count !== 3'd2 || sh_in !== 8'h21) $display("FAIL bb_simul got cnt=%0d sh_in=%h want 2/21", count, sh_in); else n_pass++;
      prev_hold = 1'b0; prev_sh = sh_in;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (prev_hold) begin
            n_chk++; if (sh_in !== prev_sh || res_valid !== 1'b1) $display("FAIL bb_hold got sh_in=%h rv=%b want %h/1", sh_in, res_valid, prev_sh); else n_pass++;
         end
         res_ready = c[0];
         if (res_valid && res_ready) begin
            n_chk++;
            if (q.size() == 0) $display("FAIL bb_toggle got unexpected %h", res_data);
            else begin e = q.pop_front(); if (res_data !== e) $display("FAIL bb_toggle got %h want %h", res_data, e); else n_pass++; end
         end
         prev_hold = res_valid && !res_ready; prev_sh = sh_in;
      end
      @(negedge clk);
      n_chk++; if (q.size() != 0 || res_valid !== 1'b0 || count !== 3'd0)
         $display("FAIL bb_end got left=%0d rv=%b cnt=%0d want 0/0/0", q.size(), res_valid, count); else n_pass++;
   endtask

   task automatic test_wrap();
      res_ready = 1'b1;
      for (int c = 0; c < 30 && (c < 9 || q.size() > 0); c++) begin
         @(negedge clk);
         cmd_valid = c < 9; cmd_data = 8'(c + 1); cmd_k = 4'(c + 1); cmd_dir = c[0];
         if (cmd_valid && cmd_ready) q.push_back(bmodel(cmd_data, cmd_k, cmd_dir));
         if (res_valid && res_ready) begin
            n_chk++;
            if (q.size() == 0) $display("FAIL wrap_res got unexpected %h", res_data);
            else begin e = q.pop_front(); if (res_data !== e) $display("FAIL wrap_res got %h want %h", res_data, e); else n_pass++; end
         end
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      n_chk++; if (q.size() != 0 || count !== 3'd0 || res_valid !== 1'b0)
         $display("FAIL wrap_end got left=%0d cnt=%0d rv=%b want 0/0/0", q.size(), count, res_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_full();
      test_back_to_back();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
